// File: rtl/mips_regfile_wb.sv
// rtl/mips_regfile_wb.sv - 32x32 MIPS register file with overflow-trap writeback gating
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding on all read ports.
module mips_regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ov_chk,
    input  logic              ov,
    input  logic              ovf_clr,
    output logic              ovf_trap,
    output logic              ovf_sticky,
    output logic [ADDR_W-1:0] ovf_rd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [0:DEPTH-1];
    logic              r_ovf_trap;
    logic              r_ovf_sticky;
    logic [ADDR_W-1:0] r_ovf_rd;

    logic              w_ovf_ev;
    logic              w_commit;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_dbg_data;

    // A trapping op that overflowed is an event even when it targets r0;
    // it never commits, so the destination keeps its old value.
    assign w_ovf_ev = wr_en & ov_chk & ov;
    assign w_commit = wr_en & (rd_addr != '0) & ~(ov_chk & ov);

    // Register array: cleared on reset, otherwise takes committed writeback data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[rd_addr] <= wr_data;
        end
    end

    // Overflow status: trap pulse mirrors last edge's event; sticky keeps the first rd until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_trap   <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_ovf_rd     <= '0;
        end else begin
            r_ovf_trap <= w_ovf_ev;
            if (w_ovf_ev && (!r_ovf_sticky || ovf_clr)) begin
                // A clear arriving with a new event lets the new event recapture.
                r_ovf_sticky <= 1'b1;
                r_ovf_rd     <= rd_addr;
            end else if (!w_ovf_ev && ovf_clr) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    // Combinational read ports; index 0 is hard-wired to zero.
    always_comb begin
        w_rs_data  = (rs_addr  == '0) ? '0 : r_regs[rs_addr];
        w_rt_data  = (rt_addr  == '0) ? '0 : r_regs[rt_addr];
        w_dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
        // Commit already excludes rd_addr == 0 and suppressed writes, so neither is forwarded.
        if (w_commit && (rs_addr == rd_addr)) begin
            w_rs_data = wr_data;
        end
        if (w_commit && (rt_addr == rd_addr)) begin
            w_rt_data = wr_data;
        end
        if (w_commit && (dbg_addr == rd_addr)) begin
            w_dbg_data = wr_data;
        end
`else
        // Without forwarding, reads show the pre-edge contents.
`endif
    end

    assign rs_data    = w_rs_data;
    assign rt_data    = w_rt_data;
    assign dbg_data   = w_dbg_data;
    assign ovf_trap   = r_ovf_trap;
    assign ovf_sticky = r_ovf_sticky;
    assign ovf_rd     = r_ovf_rd;

endmodule
